// File: rtl/fx_arb_if.sv
// fx arbiter bundle: two single-beat master request ports plus the shared fx slave bus.
// Modport master is the arbiter's view (drives fx strobes and completions); slave is the environment's view.
interface fx_arb_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          m0_req;
    logic          m0_wr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_done;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_wr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_done;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] fx_waddr;
    logic          fx_wr;
    logic [DW-1:0] fx_data;
    logic          fx_rd;
    logic [AW-1:0] fx_raddr;
    logic [DW-1:0] fx_q;

    logic          busy;

    modport master (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        output m0_done, m0_rdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        output m1_done, m1_rdata,
        output fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
        input  fx_q,
        output busy
    );

    modport slave (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        input  m0_done, m0_rdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        input  m1_done, m1_rdata,
        input  fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
        output fx_q,
        input  busy
    );
endinterface

// File: rtl/fx_arb.sv
// Round-robin arbiter/sequencer for one fx slave shared by two masters; write done at T+2, read done at T+2+RD_LAT.
// Masters hold req until their done pulse; the losing request simply waits for the next IDLE.
module fx_arb #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic     clk_sys,
    input  logic     rst_n,
    fx_arb_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_last_gnt;
    logic          r_gnt;
    logic [3:0]    r_cnt;
    logic          r_fx_wr;
    logic          r_fx_rd;
    logic [AW-1:0] r_fx_waddr;
    logic [AW-1:0] r_fx_raddr;
    logic [DW-1:0] r_fx_data;
    logic          r_m0_done;
    logic          r_m1_done;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;
    logic          r_busy;

    logic          w_gnt_vld;
    logic          w_gnt_idx;
    logic          w_sel_wr;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    // On a tie the master that did not win last time gets the bus.
    assign w_gnt_vld   = bus.m0_req | bus.m1_req;
    assign w_gnt_idx   = (bus.m0_req & bus.m1_req) ? ~r_last_gnt : bus.m1_req;
    assign w_sel_wr    = w_gnt_idx ? bus.m1_wr    : bus.m0_wr;
    assign w_sel_addr  = w_gnt_idx ? bus.m1_addr  : bus.m0_addr;
    assign w_sel_wdata = w_gnt_idx ? bus.m1_wdata : bus.m0_wdata;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_cnt      <= '0;
            r_fx_wr    <= 1'b0;
            r_fx_rd    <= 1'b0;
            r_fx_waddr <= '0;
            r_fx_raddr <= '0;
            r_fx_data  <= '0;
            r_m0_done  <= 1'b0;
            r_m1_done  <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_fx_wr   <= 1'b0;
            r_fx_rd   <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt      <= w_gnt_idx;
                        r_last_gnt <= w_gnt_idx;
                        r_busy     <= 1'b1;
                        if (w_sel_wr) begin
                            r_fx_wr    <= 1'b1;
                            r_fx_waddr <= w_sel_addr;
                            r_fx_data  <= w_sel_wdata;
                            r_state    <= WR;
                        end else begin
                            r_fx_rd    <= 1'b1;
                            r_fx_raddr <= w_sel_addr;
                            r_state    <= RD;
                        end
                    end
                end
                WR: begin
                    r_m0_done <= ~r_gnt;
                    r_m1_done <= r_gnt;
                    r_state   <= DONE;
                end
                RD: begin
                    r_cnt   <= 4'(RD_LAT - 1);
                    r_state <= RWAIT;
                end
                RWAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_gnt) begin
                            r_m1_rdata <= bus.fx_q;
                        end else begin
                            r_m0_rdata <= bus.fx_q;
                        end
                        r_m0_done <= ~r_gnt;
                        r_m1_done <= r_gnt;
                        r_state   <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fx_wr    = r_fx_wr;
    assign bus.fx_rd    = r_fx_rd;
    assign bus.fx_waddr = r_fx_waddr;
    assign bus.fx_raddr = r_fx_raddr;
    assign bus.fx_data  = r_fx_data;
    assign bus.m0_done  = r_m0_done;
    assign bus.m1_done  = r_m1_done;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.busy     = r_busy;
endmodule
